// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the display shift-register sequencer.
// The frame_latency helper gives the start-accept to done distance in clk cycles.
package shift_seq_pkg;

    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_LOAD  = 6'b000010,
        ST_SETUP = 6'b000100,
        ST_HIGH  = 6'b001000,
        ST_LATCH = 6'b010000,
        ST_DONE  = 6'b100000
    } state_e;

    function automatic int frame_latency(input int num_bytes, input int div);
        return num_bytes * (1 + 2 * BITS_PER_BYTE * div) + div + 1;
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_ser_tick.sv
// DIV-cycle phase counter; tc marks the last cycle of a SETUP, HIGH or LATCH phase.
// The counter wraps to zero on tc so back-to-back phases need no explicit clear.
module ser_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] div_cnt_q;
    logic [CNT_W-1:0] div_cnt_d;
    logic             at_last;

    assign at_last = (div_cnt_q == LAST);
    assign tc      = en && at_last;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        div_cnt_d = div_cnt_q;
        if (clr) begin
            div_cnt_d = '0;
        end else if (en) begin
            div_cnt_d = at_last ? '0 : div_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for the 8-bit load/shift register on the display path: loads each frame byte,
// steps it out LSB first on a slow ser_clk and latches the external chain once per frame.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int NUM_BYTES = 8,
    parameter int DIV       = 4,
    parameter int ROTATE    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [BITS_PER_BYTE*NUM_BYTES-1:0] frame,
    output logic                             busy,
    output logic                             done,
    output logic                             sr_sl,
    output logic                             sr_rs,
    output logic                             sr_sin,
    output logic [BITS_PER_BYTE-1:0]         sr_pdata,
    output logic                             sr_step,
    input  logic                             sr_q0,
    output logic                             ser_clk,
    output logic                             ser_dat,
    output logic                             ser_latch
);

    localparam int FRAME_W = BITS_PER_BYTE * NUM_BYTES;
    localparam int IDX_W   = $clog2(NUM_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_e                   state_q, state_d;
    logic [FRAME_W-1:0]       frame_q, frame_d;
    logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;

    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     sr_sl_q, sr_sl_d;
    logic                     sr_step_q, sr_step_d;
    logic [BITS_PER_BYTE-1:0] sr_pdata_q, sr_pdata_d;
    logic                     ser_clk_q, ser_clk_d;
    logic                     ser_dat_q, ser_dat_d;
    logic                     ser_latch_q, ser_latch_d;

    logic                     phase_en;
    logic                     phase_clr;
    logic                     phase_tc;
    logic [BITS_PER_BYTE-1:0] cur_byte;

    assign phase_en  = (state_q == ST_SETUP) || (state_q == ST_HIGH) || (state_q == ST_LATCH);
    assign phase_clr = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign cur_byte  = frame_q[int'(byte_idx_q) * BITS_PER_BYTE +: BITS_PER_BYTE];

    ser_tick #(
        .DIV (DIV)
    ) u_ser_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (phase_clr),
        .en    (phase_en),
        .tc    (phase_tc)
    );

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        byte_idx_d  = byte_idx_q;
        bit_cnt_d   = bit_cnt_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        sr_sl_d     = 1'b0;
        sr_step_d   = 1'b0;
        sr_pdata_d  = '0;
        ser_clk_d   = 1'b0;
        ser_dat_d   = 1'b0;
        ser_latch_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    frame_d    = frame;
                    byte_idx_d = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                busy_d     = 1'b1;
                sr_sl_d    = 1'b1;
                sr_step_d  = 1'b1;
                sr_pdata_d = cur_byte;
                bit_cnt_d  = '0;
                state_d    = ST_SETUP;
            end
            ST_SETUP: begin
                busy_d    = 1'b1;
                ser_dat_d = sr_q0;
                if (phase_tc) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                busy_d    = 1'b1;
                ser_clk_d = 1'b1;
                ser_dat_d = sr_q0;
                if (phase_tc) begin
                    if (bit_cnt_q != 3'd7) begin
                        sr_step_d = 1'b1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        state_d   = ST_SETUP;
                    end else if (byte_idx_q != LAST_IDX) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = ST_LOAD;
                    end else begin
                        // Eighth step on the final byte leaves the register fully cycled;
                        // before a LOAD it is skipped since the reload overwrites it anyway.
                        sr_step_d = 1'b1;
                        state_d   = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                busy_d      = 1'b1;
                ser_latch_d = 1'b1;
                if (phase_tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            byte_idx_q  <= '0;
            bit_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sr_sl_q     <= 1'b0;
            sr_step_q   <= 1'b0;
            sr_pdata_q  <= '0;
            ser_clk_q   <= 1'b0;
            ser_dat_q   <= 1'b0;
            ser_latch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            byte_idx_q  <= byte_idx_d;
            bit_cnt_q   <= bit_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sr_sl_q     <= sr_sl_d;
            sr_step_q   <= sr_step_d;
            sr_pdata_q  <= sr_pdata_d;
            ser_clk_q   <= ser_clk_d;
            ser_dat_q   <= ser_dat_d;
            ser_latch_q <= ser_latch_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sr_sl     = sr_sl_q;
    assign sr_step   = sr_step_q;
    assign sr_pdata  = sr_pdata_q;
    assign ser_clk   = ser_clk_q;
    assign ser_dat   = ser_dat_q;
    assign ser_latch = ser_latch_q;
    assign sr_rs     = (ROTATE != 0);
    assign sr_sin    = 1'b0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl: three configurations, each with a behavioural 8-bit load/shift register.
// Table-driven frames plus hand-written reset, busy-start and abort sequences.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    logic clk;
    logic rst_n;
    logic [2:0]  start_v;
    logic [15:0] frame_v [3];
    logic [7:0]  reg_q   [3];

    wire [2:0] busy_v, done_v, sl_v, rs_v, sin_v, step_v, sck_v, sdat_v, slat_v;
    wire [7:0] pdata_v [3];

    int passed = 0;
    int total  = 0;

    // Monitor state, one slot per DUT instance.
    bit   [2:0]  mon_clr;
    logic [2:0]  prev_sck, prev_lat, prev_step, prev_dat;
    int          rises [3], latch_pulses [3], latch_cycles [3], loads [3];
    int          dbl_step [3], step_in_done [3], any_active [3], dat_glitch [3];
    logic [31:0] stream [3];

    typedef struct {
        int          inst;
        logic [15:0] frame;
        logic [15:0] exp_stream;   // first transmitted bit in the MSB of the used width
        int          exp_rises;
        int          exp_loads;
        int          exp_latch;
        logic [7:0]  exp_reg;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    // inst 0: 1 byte, DIV=2, rotate
    shift_seq_ctrl #(.NUM_BYTES(1), .DIV(2), .ROTATE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .frame(frame_v[0][7:0]),
        .busy(busy_v[0]), .done(done_v[0]), .sr_sl(sl_v[0]), .sr_rs(rs_v[0]),
        .sr_sin(sin_v[0]), .sr_pdata(pdata_v[0]), .sr_step(step_v[0]), .sr_q0(reg_q[0][0]),
        .ser_clk(sck_v[0]), .ser_dat(sdat_v[0]), .ser_latch(slat_v[0])
    );

    // inst 1: 2 bytes, DIV=1, rotate
    shift_seq_ctrl #(.NUM_BYTES(2), .DIV(1), .ROTATE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .frame(frame_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sr_sl(sl_v[1]), .sr_rs(rs_v[1]),
        .sr_sin(sin_v[1]), .sr_pdata(pdata_v[1]), .sr_step(step_v[1]), .sr_q0(reg_q[1][0]),
        .ser_clk(sck_v[1]), .ser_dat(sdat_v[1]), .ser_latch(slat_v[1])
    );

    // inst 2: 1 byte, DIV=2, shift in sr_sin
    shift_seq_ctrl #(.NUM_BYTES(1), .DIV(2), .ROTATE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .frame(frame_v[2][7:0]),
        .busy(busy_v[2]), .done(done_v[2]), .sr_sl(sl_v[2]), .sr_rs(rs_v[2]),
        .sr_sin(sin_v[2]), .sr_pdata(pdata_v[2]), .sr_step(step_v[2]), .sr_q0(reg_q[2][0]),
        .ser_clk(sck_v[2]), .ser_dat(sdat_v[2]), .ser_latch(slat_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External 8-bit parallel-load / serial-shift register, shifting toward Q[0].
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (step_v[i]) begin
                if (sl_v[i]) reg_q[i] <= pdata_v[i];
                else         reg_q[i] <= {(rs_v[i] ? reg_q[i][0] : sin_v[i]), reg_q[i][7:1]};
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mon_clr[i]) begin
                rises[i] = 0; latch_pulses[i] = 0; latch_cycles[i] = 0; loads[i] = 0;
                dbl_step[i] = 0; step_in_done[i] = 0; any_active[i] = 0; dat_glitch[i] = 0;
                stream[i] = '0;
            end else begin
                if (sck_v[i] && !prev_sck[i]) begin
                    rises[i]++;
                    stream[i] = {stream[i][30:0], sdat_v[i]};
                end
                if (sck_v[i] && prev_sck[i] && (sdat_v[i] != prev_dat[i])) dat_glitch[i]++;
                if (slat_v[i] && !prev_lat[i]) latch_pulses[i]++;
                if (slat_v[i]) latch_cycles[i]++;
                if (step_v[i] && sl_v[i]) loads[i]++;
                if (step_v[i] && prev_step[i]) dbl_step[i]++;
                if (step_v[i] && done_v[i]) step_in_done[i]++;
                if (busy_v[i] || done_v[i] || sl_v[i] || step_v[i] || sck_v[i] || sdat_v[i] ||
                    slat_v[i] || sin_v[i] || (pdata_v[i] != 8'h00)) any_active[i]++;
            end
            prev_sck[i]  = sck_v[i];
            prev_lat[i]  = slat_v[i];
            prev_step[i] = step_v[i];
            prev_dat[i]  = sdat_v[i];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic mon_clear(input int i);
        mon_clr[i] = 1'b1;
        @(negedge clk);
        #1 mon_clr[i] = 1'b0;
    endtask

    // Starts one frame and returns the number of clk edges from accept to done (-1 on timeout).
    task automatic run_frame(input int i, input logic [15:0] fr, output int lat);
        @(negedge clk);
        frame_v[i] = fr;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1 start_v[i] = 1'b0;
        lat = -1;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            #1;
            if (done_v[i]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag, input int i);
        check({tag, "_busy"},  busy_v[i], 0);
        check({tag, "_done"},  done_v[i], 0);
        check({tag, "_sl"},    sl_v[i], 0);
        check({tag, "_step"},  step_v[i], 0);
        check({tag, "_pdata"}, pdata_v[i], 0);
        check({tag, "_sck"},   sck_v[i], 0);
        check({tag, "_sdat"},  sdat_v[i], 0);
        check({tag, "_latch"}, slat_v[i], 0);
    endtask

    initial begin
        int lat;
        int first_done;
        int second_done;

        vecs[0] = '{0, 16'h00A5, 16'h00A5,  8, 1, 2, 8'hA5, 36};
        vecs[1] = '{0, 16'h0001, 16'h0080,  8, 1, 2, 8'h01, 36};
        vecs[2] = '{1, 16'h01FF, 16'hFF80, 16, 2, 1, 8'h01, 36};
        vecs[3] = '{1, 16'h1234, 16'h2C48, 16, 2, 1, 8'h12, 36};
        vecs[4] = '{1, 16'hA5C3, 16'hC3A5, 16, 2, 1, 8'hA5, 36};
        vecs[5] = '{2, 16'h00FF, 16'h00FF,  8, 1, 2, 8'h00, 36};
        vecs[6] = '{2, 16'h0081, 16'h0081,  8, 1, 2, 8'h00, 36};

        rst_n   = 1'b0;
        start_v = '0;
        mon_clr = '0;
        for (int i = 0; i < 3; i++) begin
            frame_v[i] = '0;
            reg_q[i]   = 8'h00;
        end

        // Reset state, then 50 idle cycles with no start.
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_a", 0);
        check_idle_outputs("rst_b", 1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) mon_clear(i);
        repeat (50) @(negedge clk);
        #1;
        check("idle50_a", any_active[0], 0);
        check("idle50_b", any_active[1], 0);
        check("idle50_c", any_active[2], 0);

        for (int k = 0; k < 7; k++) begin
            int i;
            i = vecs[k].inst;
            mon_clear(i);
            run_frame(i, vecs[k].frame, lat);
            repeat (2) @(negedge clk);
            #1;
            check($sformatf("v%0d_latency", k), lat, vecs[k].exp_lat);
            check($sformatf("v%0d_rises", k), rises[i], vecs[k].exp_rises);
            check($sformatf("v%0d_stream", k), stream[i][15:0], vecs[k].exp_stream);
            check($sformatf("v%0d_loads", k), loads[i], vecs[k].exp_loads);
            check($sformatf("v%0d_latch_pulses", k), latch_pulses[i], 1);
            check($sformatf("v%0d_latch_cycles", k), latch_cycles[i], vecs[k].exp_latch);
            check($sformatf("v%0d_reg", k), reg_q[i], vecs[k].exp_reg);
            check($sformatf("v%0d_dbl_step", k), dbl_step[i], 0);
            check($sformatf("v%0d_dat_stable", k), dat_glitch[i], 0);
            check($sformatf("v%0d_busy_after", k), busy_v[i], 0);
        end

        // Start held high across a whole frame: one frame per IDLE visit.
        mon_clear(0);
        @(negedge clk);
        frame_v[0] = 16'h00C3;
        start_v[0] = 1'b1;
        @(posedge clk);
        first_done  = -1;
        second_done = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done_v[0]) begin
                if (first_done < 0) first_done = n;
                else begin
                    second_done = n;
                    break;
                end
            end
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("hold_first_done", first_done, frame_latency(1, 2));
        check("hold_second_done", second_done, 2 * frame_latency(1, 2) + 1);
        check("hold_loads", loads[0], 2);
        check("hold_rises", rises[0], 16);
        check("hold_stream", stream[0][15:0], 16'hC3C3);
        check("hold_latches", latch_pulses[0], 2);
        check("hold_step_in_done", step_in_done[0], 0);
        check("hold_dbl_step", dbl_step[0], 0);
        check("hold_reg", reg_q[0], 8'hC3);

        // Abort midway through byte 1 of a two-byte frame.
        mon_clear(1);
        @(negedge clk);
        frame_v[1] = 16'h5A0F;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1 start_v[1] = 1'b0;
        for (int n = 0; n < 200 && rises[1] < 10; n++) begin
            @(negedge clk);
            #1;
        end
        check("abort_reached_byte1", (rises[1] >= 10), 1);
        check("abort_busy_before", busy_v[1], 1);
        #1 rst_n = 1'b0;
        #1;
        check_idle_outputs("abort", 1);
        repeat (4) @(negedge clk);
        check("abort_no_latch", latch_pulses[1], 0);
        rst_n = 1'b1;
        mon_clear(1);
        run_frame(1, 16'h01FF, lat);
        repeat (2) @(negedge clk);
        #1;
        check("post_abort_latency", lat, 36);
        check("post_abort_rises", rises[1], 16);
        check("post_abort_stream", stream[1][15:0], 16'hFF80);
        check("post_abort_loads", loads[1], 2);
        check("post_abort_latch", latch_pulses[1], 1);
        check("post_abort_reg", reg_q[1], 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
